// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the shared-ALU controller and its combinational core.
//   - opcode encodings OP_ADD .. OP_SUBI (opcodes 7 and 15 are undefined)
//   - bit positions of the {S,V,Z,C} flags inside a 4-bit flag vector
//   - output register FSM state encoding
//   - opDefined(): tells whether an opcode has defined behaviour
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MOV  = 4'd5;
  localparam logic [3:0] OP_CMP  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SLR  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_LI   = 4'd12;
  localparam logic [3:0] OP_ADDI = 4'd13;
  localparam logic [3:0] OP_SUBI = 4'd14;

  localparam int F_S = 3;
  localparam int F_V = 2;
  localparam int F_Z = 1;
  localparam int F_C = 0;

  // EMPTY: result register holds nothing; FULL: result waiting for consumer
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic logic opDefined(input logic [3:0] op);
    return !((op == 4'd7) || (op == 4'd15));
  endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational 16-bit ALU: (op, a, b) -> (res, svzc).
// Ports:
//   i_op    opcode (alu_pkg encoding)
//   i_a     operand A
//   i_b     operand B, shift amount in [3:0], or 8-bit immediate in [7:0]
//   o_res   result (operand A for CMP, zero for undefined opcodes)
//   o_svzc  {S,V,Z,C} flags of this operation
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_res,
  output logic [3:0]  o_svzc
);

  logic [15:0]        w_imm;
  logic [15:0]        w_opB;
  logic [16:0]        w_sum;
  logic [16:0]        w_diff;
  logic [3:0]         w_amt;
  logic [16:0]        w_sll;
  logic [16:0]        w_srl;
  logic signed [16:0] w_sra;
  logic [31:0]        w_rot;
  logic [15:0]        w_val;
  logic               w_carry;
  logic               w_ovf;
  logic               w_defined;

  // Immediate forms use the sign-extended low byte of B as the second operand.
  assign w_imm  = {{8{i_b[7]}}, i_b[7:0]};
  assign w_opB  = ((i_op == OP_ADDI) || (i_op == OP_SUBI)) ? w_imm : i_b;
  assign w_sum  = {1'b0, i_a} + {1'b0, w_opB};
  assign w_diff = {1'b0, i_a} - {1'b0, w_opB};

  // Shifts are done on 17-bit vectors with one spare bit on the exit side, so
  // the spare bit ends up holding the last bit shifted out (and 0 for amount 0).
  assign w_amt  = i_b[3:0];
  assign w_sll  = {1'b0, i_a} << w_amt;
  assign w_srl  = {i_a, 1'b0} >> w_amt;
  assign w_sra  = $signed({i_a, 1'b0}) >>> w_amt;
  assign w_rot  = {i_a, i_a} << w_amt;

  // Select the value the flags are computed from, plus carry/overflow.
  // V mirrors C for the add/subtract family; every other op clears V.
  always_comb begin
    w_val     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_defined = 1'b1;
    case (i_op)
      OP_ADD, OP_ADDI: begin
        w_val   = w_sum[15:0];
        w_carry = w_sum[16];
        w_ovf   = w_sum[16];
      end
      OP_SUB, OP_SUBI, OP_CMP: begin
        w_val   = w_diff[15:0];
        w_carry = w_diff[16];
        w_ovf   = w_diff[16];
      end
      OP_AND: w_val = i_a & i_b;
      OP_OR:  w_val = i_a | i_b;
      OP_XOR: w_val = i_a ^ i_b;
      OP_MOV: w_val = i_a;
      OP_SLL: begin
        w_val   = w_sll[15:0];
        w_carry = w_sll[16];
      end
      OP_SLR: w_val = w_rot[31:16];
      OP_SRL: begin
        w_val   = w_srl[16:1];
        w_carry = w_srl[0];
      end
      OP_SRA: begin
        w_val   = w_sra[16:1];
        w_carry = w_sra[0];
      end
      OP_LI:  w_val = w_imm;
      default: w_defined = 1'b0;
    endcase
  end

  // CMP keeps operand A as its visible result; undefined ops report zero.
  always_comb begin
    o_res  = '0;
    o_svzc = 4'b0010;
    if (w_defined) begin
      o_res         = (i_op == OP_CMP) ? i_a : w_val;
      o_svzc[F_S]   = w_val[15];
      o_svzc[F_V]   = w_ovf;
      o_svzc[F_Z]   = (w_val == 16'h0000);
      o_svzc[F_C]   = w_carry;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
// Shares one alu_core between the execute stage (req0) and the address/PC
// unit (req1) with round-robin arbitration, a single registered result with
// valid/ready handshake, and the architectural {S,V,Z,C} flag register.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   r0_valid/r0_ready      req0 handshake (ready is combinational)
//   r0_op/r0_a/r0_b        req0 opcode and operands
//   r0_fwe                 req0 op writes the flag register
//   r1_valid/r1_ready      req1 handshake
//   r1_op/r1_a/r1_b        req1 opcode and operands (never writes flags)
//   o_valid/o_ready        result register handshake
//   o_tag                  0 = req0 result, 1 = req1 result
//   o_res/o_svzc           result and its flags
//   flags                  architectural {S,V,Z,C}
// ---------------------------------------------------------------------------
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int W   = 16,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic [OPW-1:0] r0_op,
  input  logic [W-1:0]   r0_a,
  input  logic [W-1:0]   r0_b,
  input  logic           r0_fwe,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic [OPW-1:0] r1_op,
  input  logic [W-1:0]   r1_a,
  input  logic [W-1:0]   r1_b,
  output logic           o_valid,
  input  logic           o_ready,
  output logic           o_tag,
  output logic [W-1:0]   o_res,
  output logic [3:0]     o_svzc,
  output logic [3:0]     flags
);

  state_t         r_state;
  state_t         w_stateNext;
  logic           r_rrLast;
  logic           r_tag;
  logic [W-1:0]   r_res;
  logic [3:0]     r_svzc;
  logic [3:0]     r_flags;
  logic           w_canIssue;
  logic           w_grant0;
  logic           w_grant1;
  logic           w_grant;
  logic [OPW-1:0] w_op;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic [W-1:0]   w_aluRes;
  logic [3:0]     w_aluSvzc;

  // Output FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Arbitration and next-state logic. A new op may issue when the result
  // register is empty or is being drained this cycle. On a tie the requester
  // not granted last wins; r_rrLast = 1 means req1 was granted last. Readies
  // are held low while reset is asserted so nothing is accepted into a
  // register that is being cleared.
  always_comb begin
    w_stateNext = r_state;
    w_canIssue  = (r_state == ST_EMPTY) || o_ready;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    if (!rst && w_canIssue) begin
      if (r0_valid && (!r1_valid || r_rrLast)) begin
        w_grant0 = 1'b1;
      end else if (r1_valid) begin
        w_grant1 = 1'b1;
      end
    end
    case (r_state)
      ST_EMPTY: if (w_grant0 || w_grant1) w_stateNext = ST_FULL;
      ST_FULL:  if (o_ready && !(w_grant0 || w_grant1)) w_stateNext = ST_EMPTY;
      default:  w_stateNext = ST_EMPTY;
    endcase
  end

  assign w_grant  = w_grant0 | w_grant1;
  assign r0_ready = w_grant0;
  assign r1_ready = w_grant1;

  assign w_op = w_grant1 ? r1_op : r0_op;
  assign w_a  = w_grant1 ? r1_a  : r0_a;
  assign w_b  = w_grant1 ? r1_b  : r0_b;

  alu_core u_core (
    .i_op   (w_op),
    .i_a    (w_a),
    .i_b    (w_b),
    .o_res  (w_aluRes),
    .o_svzc (w_aluSvzc)
  );

  // Result register, round-robin history and flag register. Everything is
  // captured at the grant edge; without a grant the result simply holds.
  // Only a flag-writing req0 op with a defined opcode touches the flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag    <= 1'b0;
      r_res    <= '0;
      r_svzc   <= '0;
      r_flags  <= '0;
      r_rrLast <= 1'b1;
    end else if (w_grant) begin
      r_tag    <= w_grant1;
      r_res    <= w_aluRes;
      r_svzc   <= w_aluSvzc;
      r_rrLast <= w_grant1;
      if (w_grant0 && r0_fwe && opDefined(r0_op)) begin
        r_flags <= w_aluSvzc;
      end
    end
  end

  assign o_valid = (r_state == ST_FULL);
  assign o_tag   = r_tag;
  assign o_res   = r_res;
  assign o_svzc  = r_svzc;
  assign flags   = r_flags;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
// Directed scenarios followed by a randomized phase, all checked against a
// behavioural model of the shared ALU, its arbitration and flag register.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;

  localparam logic [3:0] T_ADD  = 4'd0;
  localparam logic [3:0] T_SUB  = 4'd1;
  localparam logic [3:0] T_AND  = 4'd2;
  localparam logic [3:0] T_OR   = 4'd3;
  localparam logic [3:0] T_XOR  = 4'd4;
  localparam logic [3:0] T_MOV  = 4'd5;
  localparam logic [3:0] T_CMP  = 4'd6;
  localparam logic [3:0] T_SLL  = 4'd8;
  localparam logic [3:0] T_SLR  = 4'd9;
  localparam logic [3:0] T_SRL  = 4'd10;
  localparam logic [3:0] T_SRA  = 4'd11;
  localparam logic [3:0] T_LI   = 4'd12;
  localparam logic [3:0] T_ADDI = 4'd13;
  localparam logic [3:0] T_SUBI = 4'd14;

  logic        clk;
  logic        rst;
  logic        r0_valid;
  logic        r0_ready;
  logic [3:0]  r0_op;
  logic [15:0] r0_a;
  logic [15:0] r0_b;
  logic        r0_fwe;
  logic        r1_valid;
  logic        r1_ready;
  logic [3:0]  r1_op;
  logic [15:0] r1_a;
  logic [15:0] r1_b;
  logic        o_valid;
  logic        o_ready;
  logic        o_tag;
  logic [15:0] o_res;
  logic [3:0]  o_svzc;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  // Model state: what the result register and flag register should hold,
  // and which requester was granted most recently (1 = req1).
  logic        mValid;
  logic        mTag;
  logic [15:0] mRes;
  logic [3:0]  mSvzc;
  logic [3:0]  mFlags;
  logic        mLast;

  alu_share_ctrl #(.W(16), .OPW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .r0_valid (r0_valid),
    .r0_ready (r0_ready),
    .r0_op    (r0_op),
    .r0_a     (r0_a),
    .r0_b     (r0_b),
    .r0_fwe   (r0_fwe),
    .r1_valid (r1_valid),
    .r1_ready (r1_ready),
    .r1_op    (r1_op),
    .r1_a     (r1_a),
    .r1_b     (r1_b),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_tag    (o_tag),
    .o_res    (o_res),
    .o_svzc   (o_svzc),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference ALU written straight from the opcode rules: plain arithmetic
  // for add/subtract, bit-at-a-time loops for shifts and rotates.
  function automatic void refAlu(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, output logic [15:0] res,
                                 output logic [3:0] svzc);
    logic [15:0] imm;
    logic [15:0] opnd;
    logic [15:0] val;
    logic        carry;
    logic        ovf;
    int unsigned sum;
    int          amt;
    imm   = {{8{b[7]}}, b[7:0]};
    opnd  = ((op == T_ADDI) || (op == T_SUBI)) ? imm : b;
    amt   = int'(b[3:0]);
    carry = 1'b0;
    ovf   = 1'b0;
    val   = '0;
    if ((op == 4'd7) || (op == 4'd15)) begin
      res  = '0;
      svzc = 4'b0010;
      return;
    end
    case (op)
      T_ADD, T_ADDI: begin
        sum   = int'(a) + int'(opnd);
        val   = 16'(sum);
        carry = (sum > 65535);
        ovf   = carry;
      end
      T_SUB, T_SUBI, T_CMP: begin
        val   = a - opnd;
        carry = (a < opnd);
        ovf   = carry;
      end
      T_AND: val = a & b;
      T_OR:  val = a | b;
      T_XOR: val = a ^ b;
      T_MOV: val = a;
      T_SLL: begin
        val = a;
        for (int k = 0; k < amt; k++) begin
          carry = val[15];
          val   = {val[14:0], 1'b0};
        end
      end
      T_SLR: begin
        val = a;
        for (int k = 0; k < amt; k++) val = {val[14:0], val[15]};
      end
      T_SRL: begin
        val = a;
        for (int k = 0; k < amt; k++) begin
          carry = val[0];
          val   = {1'b0, val[15:1]};
        end
      end
      T_SRA: begin
        val = a;
        for (int k = 0; k < amt; k++) begin
          carry = val[0];
          val   = {val[15], val[15:1]};
        end
      end
      T_LI:    val = imm;
      default: val = '0;
    endcase
    svzc = {val[15], ovf, (val == 16'h0000), carry};
    res  = (op == T_CMP) ? a : val;
  endfunction

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of inputs just after the falling edge.
  task automatic applyStimulus(input logic iRst,
                               input logic v0, input logic [3:0] op0, input logic [15:0] a0,
                               input logic [15:0] b0, input logic f0,
                               input logic v1, input logic [3:0] op1, input logic [15:0] a1,
                               input logic [15:0] b1, input logic oRdy);
    @(negedge clk);
    rst      = iRst;
    r0_valid = v0;
    r0_op    = op0;
    r0_a     = a0;
    r0_b     = b0;
    r0_fwe   = f0;
    r1_valid = v1;
    r1_op    = op1;
    r1_a     = a1;
    r1_b     = b1;
    o_ready  = oRdy;
  endtask

  // Check the readies against the arbitration rules, advance the model over
  // the rising edge, then check every registered output.
  task automatic checkOutput(output logic g0, output logic g1);
    logic        canIssue;
    logic [15:0] res;
    logic [3:0]  svzc;
    #1;
    canIssue = !mValid || o_ready;
    g0 = !rst && canIssue && r0_valid && (!r1_valid || mLast);
    g1 = !rst && canIssue && r1_valid && !g0;
    check("r0_ready", {15'b0, r0_ready}, {15'b0, g0});
    check("r1_ready", {15'b0, r1_ready}, {15'b0, g1});
    @(posedge clk);
    if (rst) begin
      mValid = 1'b0;
      mTag   = 1'b0;
      mRes   = '0;
      mSvzc  = '0;
      mFlags = '0;
      mLast  = 1'b1;
    end else if (g0 || g1) begin
      if (g1) refAlu(r1_op, r1_a, r1_b, res, svzc);
      else    refAlu(r0_op, r0_a, r0_b, res, svzc);
      mValid = 1'b1;
      mTag   = g1;
      mRes   = res;
      mSvzc  = svzc;
      mLast  = g1;
      if (g0 && r0_fwe && (r0_op != 4'd7) && (r0_op != 4'd15)) mFlags = svzc;
    end else if (o_ready) begin
      mValid = 1'b0;
    end
    #1;
    check("o_valid", {15'b0, o_valid}, {15'b0, mValid});
    check("o_tag",   {15'b0, o_tag},   {15'b0, mTag});
    check("o_res",   o_res,            mRes);
    check("o_svzc",  {12'b0, o_svzc},  {12'b0, mSvzc});
    check("flags",   {12'b0, flags},   {12'b0, mFlags});
  endtask

  initial begin
    logic        g0;
    logic        g1;
    logic        nv0;
    logic        nv1;
    logic [3:0]  op0;
    logic [3:0]  op1;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] b0;
    logic [15:0] b1;
    logic        f0;
    logic        rstNow;
    logic        rdy;

    rst = 1'b1; r0_valid = 0; r0_op = 0; r0_a = 0; r0_b = 0; r0_fwe = 0;
    r1_valid = 0; r1_op = 0; r1_a = 0; r1_b = 0; o_ready = 0;
    mValid = 0; mTag = 0; mRes = 0; mSvzc = 0; mFlags = 0; mLast = 1;

    // Reset values
    applyStimulus(1, 0, T_ADD, 0, 0, 0, 0, T_ADD, 0, 0, 0);
    checkOutput(g0, g1);
    applyStimulus(1, 0, T_ADD, 0, 0, 0, 0, T_ADD, 0, 0, 0);
    checkOutput(g0, g1);
    check("reset_valid", {15'b0, o_valid}, 16'h0);
    check("reset_flags", {12'b0, flags}, 16'h0);

    // 1: ADD overflow into the sign bit
    applyStimulus(0, 1, T_ADD, 16'h7FFF, 16'h0001, 1, 0, T_ADD, 0, 0, 1);
    checkOutput(g0, g1);
    check("t1_res",   o_res, 16'h8000);
    check("t1_svzc",  {12'b0, o_svzc}, 16'h0008);
    check("t1_flags", {12'b0, flags},  16'h0008);

    // 5: req1 CMP never touches flags
    applyStimulus(0, 0, T_ADD, 0, 0, 0, 1, T_CMP, 16'h0003, 16'h0004, 1);
    checkOutput(g0, g1);
    check("t5_res",   o_res, 16'h0003);
    check("t5_tag",   {15'b0, o_tag}, 16'h0001);
    check("t5_svzc",  {12'b0, o_svzc}, 16'h000D);
    check("t5_flags", {12'b0, flags},  16'h0008);

    // 2: both requesters valid, alternating grants
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, T_SUB, 16'h0005, 16'h0005, 1, 1, T_ADDI, 16'h0010, 16'h00FF, 1);
      checkOutput(g0, g1);
      check("t2_tag", {15'b0, o_tag}, (i == 1) ? 16'h0001 : 16'h0000);
      check("t2_res", o_res, (i == 1) ? 16'h000F : 16'h0000);
      check("t2_flags", {12'b0, flags}, 16'h0002);
    end

    // 3: consumer stalls, everything holds
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, T_XOR, 16'h00FF, 16'h0F0F, 0, 0, T_ADD, 0, 0, 0);
      checkOutput(g0, g1);
      check("t3_hold_ready", {15'b0, r0_ready}, 16'h0);
      check("t3_hold_res", o_res, 16'h0000);
    end
    applyStimulus(0, 1, T_XOR, 16'h00FF, 16'h0F0F, 0, 0, T_ADD, 0, 0, 1);
    checkOutput(g0, g1);
    check("t3_release_res", o_res, 16'h0FF0);

    // 4: shifts and rotate
    applyStimulus(0, 1, T_SRA, 16'h8001, 16'h0001, 1, 0, T_ADD, 0, 0, 1);
    checkOutput(g0, g1);
    check("t4_sra_res", o_res, 16'hC000);
    check("t4_sra_c", {15'b0, o_svzc[0]}, 16'h0001);
    applyStimulus(0, 1, T_SLL, 16'h8000, 16'h0001, 1, 0, T_ADD, 0, 0, 1);
    checkOutput(g0, g1);
    check("t4_sll_res", o_res, 16'h0000);
    check("t4_sll_svzc", {12'b0, o_svzc}, 16'h0003);
    applyStimulus(0, 1, T_SLR, 16'h8001, 16'h0004, 1, 0, T_ADD, 0, 0, 1);
    checkOutput(g0, g1);
    check("t4_slr_res", o_res, 16'h0018);
    applyStimulus(0, 1, T_SRL, 16'h1234, 16'h0000, 1, 0, T_ADD, 0, 0, 1);
    checkOutput(g0, g1);
    check("t4_srl0_res", o_res, 16'h1234);
    applyStimulus(0, 1, 4'd7, 16'h1234, 16'h0001, 1, 0, T_ADD, 0, 0, 1);
    checkOutput(g0, g1);
    check("t4_undef_svzc", {12'b0, o_svzc}, 16'h0002);

    // 6: reset while FULL with both requesters valid
    applyStimulus(0, 1, T_LI, 0, 16'h0080, 1, 1, T_MOV, 16'h5555, 0, 0);
    checkOutput(g0, g1);
    applyStimulus(1, 1, T_LI, 0, 16'h0080, 1, 1, T_MOV, 16'h5555, 0, 0);
    checkOutput(g0, g1);
    check("t6_valid", {15'b0, o_valid}, 16'h0);
    check("t6_flags", {12'b0, flags}, 16'h0);
    applyStimulus(0, 1, T_LI, 0, 16'h0080, 1, 1, T_MOV, 16'h5555, 0, 1);
    checkOutput(g0, g1);
    check("t6_first_tag", {15'b0, o_tag}, 16'h0);
    check("t6_first_res", o_res, 16'hFF80);

    // Randomized traffic; a requester keeps its op until it is accepted.
    g0 = 1'b1; g1 = 1'b1;
    nv0 = 0; nv1 = 0; op0 = 0; op1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0; f0 = 0;
    for (int i = 0; i < 600; i++) begin
      if (!nv0 || g0) begin
        nv0 = ($urandom_range(0, 3) != 0);
        op0 = 4'($urandom_range(0, 15));
        a0  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        b0  = 16'($urandom);
        f0  = 1'($urandom_range(0, 1));
      end
      if (!nv1 || g1) begin
        nv1 = ($urandom_range(0, 2) != 0);
        op1 = 4'($urandom_range(0, 15));
        a1  = 16'($urandom);
        b1  = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
      end
      rstNow = ($urandom_range(0, 79) == 0);
      rdy    = ($urandom_range(0, 3) != 0);
      applyStimulus(rstNow, nv0, op0, a0, b0, f0, nv1, op1, a1, b1, rdy);
      checkOutput(g0, g1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
